// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Round-robin scheduler that shares one 8N1 UART transmitter among NUM_REQ
// byte requesters. The transmitter has no busy/ready feedback, so after each
// issue the scheduler blocks for a fixed frame time derived from the
// transmitter's bit-period divider. A byte is never handed over while the
// transmitter is still shifting out the previous one.
//
// Ports:
//   clk            system clock
//   rstn           synchronous reset, active-low
//   i_en           1 = new grants allowed; 0 = finish current frame, then park
//   i_req_valid    per-requester byte pending, held until its o_req_ready
//   i_req_data     byte for requester i on bits [8i+7:8i]
//   o_req_ready    one-cycle, one-hot accept pulse back to the winner
//   o_grant_id     index of the most recently granted requester
//   o_tdata        byte to the UART transmitter (holds until the next grant)
//   o_tdata_req    one-cycle start pulse to the UART transmitter
//   o_busy         high while a frame is in flight
//
// Timing: the grant edge loads the frame counter with FRAME-1 and enters
// WAIT. WAIT lasts FRAME cycles (including the tdata_req cycle), then at
// least one IDLE cycle follows, so back-to-back issues are FRAME+1 apart.
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int NUM_REQ  = 4,    // 2..8 requesters
  parameter int BAUD_DIV = 108,  // bit period = BAUD_DIV+1 clk cycles
  parameter int GAP      = 1     // extra idle cycles after each frame
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_en,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic [7:0]                 o_tdata,
  output logic                       o_tdata_req,
  output logic                       o_busy
);

  // One start bit, eight data bits and one stop bit, plus the idle gap.
  localparam int FRAME = 10 * (BAUD_DIV + 1) + GAP;
  localparam int CNT_W = $clog2(FRAME);
  localparam int ID_W  = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Registered state and outputs
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [ID_W-1:0]    r_grant_id;
  logic [7:0]         r_tdata;
  logic               r_tdata_req;
  logic               r_busy;

  // Next-state values
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [ID_W-1:0]    w_rr_ptr_nxt;
  logic [NUM_REQ-1:0] w_req_ready_nxt;
  logic [ID_W-1:0]    w_grant_id_nxt;
  logic [7:0]         w_tdata_nxt;
  logic               w_tdata_req_nxt;
  logic               w_busy_nxt;

  // Arbitration result
  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_win_inc;

  // Index base+off folded back into 0..NUM_REQ-1. The fold is done with a
  // compare/subtract so it is correct for non-power-of-2 NUM_REQ, where the
  // natural ID_W-bit overflow would land on an unused index.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid requester starting at r_rr_ptr.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // at the top; a path that leaves one unassigned would infer a latch.
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_rr_ptr, k);
      end
    end
  end

  // Pointer moves to the slot after the winner, wrapping explicitly.
  assign w_win_inc = (w_win == ID_LAST) ? '0 : w_win + ID_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_grant_id_nxt  = r_grant_id;
    w_tdata_nxt     = r_tdata;
    w_busy_nxt      = r_busy;
    // Handshake pulses are single-cycle: they are only ever set on the
    // grant edge and fall back to zero everywhere else.
    w_tdata_req_nxt = 1'b0;
    w_req_ready_nxt = '0;

    case (r_state)
      S_IDLE: begin
        if (i_en && w_found) begin
          w_tdata_nxt            = i_req_data[{w_win, 3'b000} +: 8];
          w_tdata_req_nxt        = 1'b1;
          w_req_ready_nxt[w_win] = 1'b1;
          w_grant_id_nxt         = w_win;
          w_rr_ptr_nxt           = w_win_inc;
          w_cnt_nxt              = CNT_LOAD;
          w_busy_nxt             = 1'b1;
          w_state_nxt            = S_WAIT;
        end
      end

      S_WAIT: begin
        // Requests are ignored here; the frame always runs to completion,
        // even if i_en drops, because the transmitter cannot be aborted.
        if (r_cnt == '0) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // Reset is synchronous: it only takes effect on a clock edge. The UART
    // shares rstn, so both sides restart from an idle line together.
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_req_ready <= '0;
      r_grant_id  <= '0;
      r_tdata     <= 8'h00;
      r_tdata_req <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_tdata     <= w_tdata_nxt;
      r_tdata_req <= w_tdata_req_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_grant_id  = r_grant_id;
  assign o_tdata     = r_tdata;
  assign o_tdata_req = r_tdata_req;
  assign o_busy      = r_busy;

endmodule
